// File: rtl/kband_pkg.sv
// Shared definitions for the burst reader: CSR map, CTRL/STATUS bit positions
// and the job FSM state type.
package kband_pkg;

  localparam logic [1:0] CSR_START  = 2'd0;
  localparam logic [1:0] CSR_LEN    = 2'd1;
  localparam logic [1:0] CSR_CTRL   = 2'd2;
  localparam logic [1:0] CSR_STATUS = 2'd3;

  localparam int CTRL_GO     = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/kband_sync_fifo.sv
// Single-clock FIFO with a first-word-fall-through head and an occupancy count.
// A push while full is taken only if a pop frees a slot in the same cycle.
module kband_sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/kband_burst_reader.sv
// CSR-programmed Avalon-MM burst reader: fetches LEN beats from START in bursts
// of up to MAX_BURST and replays them on a valid/ready stream with st_last.
module kband_burst_reader
  import kband_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 30,
  parameter int BURST_W    = 5,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [1:0]          csr_address,
  input  logic                csr_write,
  input  logic [31:0]         csr_writedata,
  input  logic                csr_read,
  output logic [31:0]         csr_readdata,
  output logic                irq,
  output logic [ADDR_W-1:0]   m0_address,
  output logic                m0_read,
  output logic [BURST_W-1:0]  m0_burstcount,
  output logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_waitrequest,
  input  logic [DATA_W-1:0]   m0_readdata,
  input  logic                m0_readdatavalid,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_valid,
  input  logic                st_ready,
  output logic                st_last,
  output state_t              dbg_state
);

  localparam int MAX_BURST = 1 << (BURST_W - 1);
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(DATA_W / 8);

  state_t             state;
  logic [ADDR_W-1:0]  start_reg;
  logic [31:0]        len_reg;
  logic [31:0]        req_left;
  logic [31:0]        sent_cnt;
  logic               irq_en;
  logic               done;
  logic [CNT_W-1:0]   out_cnt;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic               busy;
  logic               wr_start, wr_len, wr_ctrl, wr_status, go;
  logic               accepted, fifo_push, st_fire, last_fire, credit_ok;
  logic [BURST_W-1:0] next_burst;
  logic [CNT_W:0]     committed;
  logic [31:0]        rd_mux;

  assign busy          = (state != ST_IDLE);
  assign dbg_state     = state;
  assign m0_byteenable = '1;

  assign wr_start  = csr_write && (csr_address == CSR_START);
  assign wr_len    = csr_write && (csr_address == CSR_LEN);
  assign wr_ctrl   = csr_write && (csr_address == CSR_CTRL);
  assign wr_status = csr_write && (csr_address == CSR_STATUS);
  assign go        = wr_ctrl && csr_writedata[CTRL_GO];

  // Stream handshake: a beat moves on a rising edge where st_valid && st_ready;
  // st_valid never depends on st_ready, and st_data/st_last hold until taken.
  assign st_valid  = !fifo_empty;
  assign st_fire   = st_valid && st_ready;
  assign st_last   = st_valid && busy && (sent_cnt == len_reg - 32'd1);
  assign last_fire = st_fire && st_last;

  assign accepted  = m0_read && !m0_waitrequest;
  // Beats arriving with nothing outstanding belong to a job killed by reset.
  assign fifo_push = m0_readdatavalid && (out_cnt != '0);

  // Credit: buffered plus outstanding beats plus the new burst must fit.
  assign next_burst = (req_left >= 32'(MAX_BURST)) ? BURST_W'(MAX_BURST)
                                                   : req_left[BURST_W-1:0];
  assign committed  = {1'b0, fifo_count} + {1'b0, out_cnt};
  assign credit_ok  = (committed + (CNT_W+1)'(next_burst)) <= (CNT_W+1)'(FIFO_DEPTH);

  always_comb begin
    rd_mux = '0;
    case (csr_address)
      CSR_START:  rd_mux = 32'(start_reg);
      CSR_LEN:    rd_mux = len_reg;
      CSR_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en;
      CSR_STATUS: begin
        rd_mux[STATUS_BUSY] = busy;
        rd_mux[STATUS_DONE] = done;
      end
      default:    rd_mux = '0;
    endcase
  end

  kband_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .push      (fifo_push),
    .push_data (m0_readdata),
    .pop       (st_fire),
    .head_data (st_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state         <= ST_IDLE;
      start_reg     <= '0;
      len_reg       <= '0;
      irq_en        <= 1'b0;
      done          <= 1'b0;
      req_left      <= '0;
      sent_cnt      <= '0;
      out_cnt       <= '0;
      m0_read       <= 1'b0;
      m0_address    <= '0;
      m0_burstcount <= '0;
      irq           <= 1'b0;
      csr_readdata  <= '0;
    end else begin
      irq          <= done && irq_en;
      csr_readdata <= csr_read ? rd_mux : 32'd0;
      out_cnt      <= out_cnt + (accepted  ? CNT_W'(m0_burstcount) : CNT_W'(0))
                              - (fifo_push ? CNT_W'(1) : CNT_W'(0));
      if (wr_ctrl) irq_en <= csr_writedata[CTRL_IRQ_EN];
      if (wr_status && csr_writedata[STATUS_DONE]) done <= 1'b0;
      if (st_fire) sent_cnt <= sent_cnt + 32'd1;

      case (state)
        ST_IDLE: begin
          if (wr_start) start_reg <= csr_writedata[ADDR_W-1:0];
          if (wr_len)   len_reg   <= csr_writedata;
          if (go) begin
            if (len_reg == 32'd0) begin
              done <= 1'b1;
            end else begin
              state      <= ST_ISSUE;
              done       <= 1'b0;
              req_left   <= len_reg;
              sent_cnt   <= '0;
              m0_address <= start_reg;
            end
          end
        end
        ST_ISSUE: begin
          if (accepted) begin
            m0_read    <= 1'b0;
            m0_address <= m0_address + ADDR_W'(m0_burstcount) * BEAT_BYTES;
            req_left   <= req_left - 32'(m0_burstcount);
            if (req_left == 32'(m0_burstcount)) state <= ST_DRAIN;
          end else if (!m0_read && credit_ok) begin
            m0_read       <= 1'b1;
            m0_burstcount <= next_burst;
          end
        end
        ST_DRAIN: state <= ST_DRAIN;
        default:  state <= ST_IDLE;
      endcase

      if (busy && last_fire) begin
        state <= ST_IDLE;
        done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kband_burst_reader.sv
// Randomized bench for kband_burst_reader: an Avalon slave model with random
// waits/latency, a random stream sink, and an expected-beat scoreboard.
module tb_kband_burst_reader;
  import kband_pkg::*;

  localparam int DATA_W     = 128;
  localparam int ADDR_W     = 30;
  localparam int BURST_W    = 5;
  localparam int FIFO_DEPTH = 64;
  localparam int MAX_BURST  = 16;
  localparam int BEAT_BYTES = 16;

  logic                clk_clk = 1'b0;
  logic                reset_reset_n = 1'b0;
  logic [1:0]          csr_address;
  logic                csr_write;
  logic [31:0]         csr_writedata;
  logic                csr_read;
  logic [31:0]         csr_readdata;
  logic                irq;
  logic [ADDR_W-1:0]   m0_address;
  logic                m0_read;
  logic [BURST_W-1:0]  m0_burstcount;
  logic [DATA_W/8-1:0] m0_byteenable;
  logic                m0_waitrequest;
  logic [DATA_W-1:0]   m0_readdata;
  logic                m0_readdatavalid;
  logic [DATA_W-1:0]   st_data;
  logic                st_valid;
  logic                st_ready;
  logic                st_last;
  state_t              dbg_state;

  kband_burst_reader #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .BURST_W (BURST_W), .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_clk          (clk_clk),
    .reset_reset_n    (reset_reset_n),
    .csr_address      (csr_address),
    .csr_write        (csr_write),
    .csr_writedata    (csr_writedata),
    .csr_read         (csr_read),
    .csr_readdata     (csr_readdata),
    .irq              (irq),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_burstcount    (m0_burstcount),
    .m0_byteenable    (m0_byteenable),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .st_data          (st_data),
    .st_valid         (st_valid),
    .st_ready         (st_ready),
    .st_last          (st_last),
    .dbg_state        (dbg_state)
  );

  // clock / reset
  initial forever #5 clk_clk = ~clk_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  int                exp_burst_q[$];
  int                job_len = 0;
  int                beats_seen = 0;

  // slave / sink model state
  logic [ADDR_W-1:0] pend_addr_q[$];
  int                pend_due_q[$];
  int   cyc = 0;
  int   forced_wait = 0;
  logic wait_rand = 1'b0;
  int   ready_mode = 1;
  int   req_cycles = 0;
  int   hold_err = 0;
  int   first_req_cycles = 0;
  int   job_accepts = 0;
  int   accept_cnt = 0;
  int   accepted_beats = 0;
  int   streamed_beats = 0;
  int   max_inflight = 0;
  logic [ADDR_W-1:0]  cap_addr;
  logic [BURST_W-1:0] cap_burst;

  function automatic logic [DATA_W-1:0] beat_data(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = {2'b00, a};
    return {w ^ 32'hDEAD_0003, w ^ 32'h5A5A_0002, ~w, w * 32'd3 + 32'd1};
  endfunction

  // Beat i of a job lives at START + i*BEAT_BYTES; bursts are greedy MAX_BURST chunks.
  task automatic model_job(input logic [ADDR_W-1:0] start, input int len);
    logic [ADDR_W-1:0] a;
    int rem;
    int b;
    a = start;
    rem = len;
    exp_q.delete();
    exp_addr_q.delete();
    exp_burst_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(beat_data(start + ADDR_W'(i * BEAT_BYTES)));
    while (rem > 0) begin
      b = (rem > MAX_BURST) ? MAX_BURST : rem;
      exp_addr_q.push_back(a);
      exp_burst_q.push_back(b);
      a = a + ADDR_W'(b * BEAT_BYTES);
      rem -= b;
    end
    job_len = len;
    beats_seen = 0;
    job_accepts = 0;
    accepted_beats = 0;
    streamed_beats = 0;
    max_inflight = 0;
  endtask

  // Avalon slave, stream sink and monitors: inputs change on the falling edge.
  initial begin
    m0_waitrequest = 1'b0;
    m0_readdatavalid = 1'b0;
    m0_readdata = '0;
    st_ready = 1'b0;
    forever begin
      @(negedge clk_clk);
      cyc++;
      if (m0_read && forced_wait > 0) begin
        m0_waitrequest = 1'b1;
        forced_wait--;
      end else begin
        m0_waitrequest = wait_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      if (reset_reset_n && m0_read) begin
        if (req_cycles == 0) begin
          cap_addr = m0_address;
          cap_burst = m0_burstcount;
        end else if (m0_address != cap_addr || m0_burstcount != cap_burst) begin
          hold_err++;
        end
        req_cycles++;
        if (!m0_waitrequest) begin
          accept_cnt++;
          if (job_accepts == 0) first_req_cycles = req_cycles;
          job_accepts++;
          req_cycles = 0;
          if (exp_addr_q.size() == 0) begin
            check_eq("req_extra", 1, 0);
          end else begin
            check_eq("req_addr", m0_address, exp_addr_q.pop_front());
            check_eq("req_burst", m0_burstcount, exp_burst_q.pop_front());
          end
          for (int b = 0; b < int'(m0_burstcount); b++) begin
            pend_addr_q.push_back(m0_address + ADDR_W'(b * BEAT_BYTES));
            pend_due_q.push_back(cyc + 2);
          end
          accepted_beats += int'(m0_burstcount);
        end
      end else if (reset_reset_n && req_cycles > 0) begin
        hold_err++;
        req_cycles = 0;
      end

      if (reset_reset_n && pend_addr_q.size() > 0 && pend_due_q[0] <= cyc &&
          $urandom_range(0, 3) != 0) begin
        m0_readdatavalid = 1'b1;
        m0_readdata = beat_data(pend_addr_q.pop_front());
        void'(pend_due_q.pop_front());
      end else begin
        m0_readdatavalid = 1'b0;
        m0_readdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      end

      case (ready_mode)
        0:       st_ready = 1'b0;
        1:       st_ready = 1'b1;
        default: st_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (reset_reset_n && st_valid && st_ready) begin
        streamed_beats++;
        if (exp_q.size() == 0) begin
          check_eq("st_extra", 1, 0);
        end else begin
          check_eq("st_data", st_data, exp_q.pop_front());
          check_eq("st_last", st_last, (beats_seen == job_len - 1));
        end
        beats_seen++;
      end
      if (accepted_beats - streamed_beats > max_inflight)
        max_inflight = accepted_beats - streamed_beats;
    end
  end

  // driver tasks
  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_address = a;
    csr_writedata = d;
    csr_write = 1'b1;
    @(posedge clk_clk); #1;
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    csr_address = a;
    csr_read = 1'b1;
    @(posedge clk_clk); #1;
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  task automatic start_job(input logic [ADDR_W-1:0] start, input int len, input logic ien);
    csr_wr(CSR_START, 32'(start));
    csr_wr(CSR_LEN, len);
    model_job(start, len);
    csr_wr(CSR_CTRL, {30'd0, ien, 1'b1});
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic [31:0] s;
    int n;
    s = '0;
    n = 0;
    while (!s[STATUS_DONE] && n < budget) begin
      csr_rd(CSR_STATUS, s);
      n++;
    end
    check_eq({tag, "_done"}, s[STATUS_DONE], 1'b1);
    check_eq({tag, "_busy"}, s[STATUS_BUSY], 1'b0);
    check_eq({tag, "_beats"}, beats_seen, job_len);
    check_eq({tag, "_reqs_left"}, exp_addr_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_m0_read"}, m0_read, 1'b0);
    check_eq({tag, "_m0_address"}, m0_address, 0);
    check_eq({tag, "_m0_burstcount"}, m0_burstcount, 0);
    check_eq({tag, "_st_valid"}, st_valid, 1'b0);
    check_eq({tag, "_st_last"}, st_last, 1'b0);
    check_eq({tag, "_irq"}, irq, 1'b0);
    check_eq({tag, "_csr_readdata"}, csr_readdata, 0);
    check_eq({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  initial begin
    logic [31:0] rd;
    int n;
    int acc_before;
    csr_address = '0;
    csr_write = 1'b0;
    csr_writedata = '0;
    csr_read = 1'b0;
    reset_reset_n = 1'b0;
    repeat (3) @(posedge clk_clk);
    #1;
    check_reset_outputs("por");
    reset_reset_n = 1'b1;
    check_eq("byteenable", m0_byteenable, {(DATA_W/8){1'b1}});
    csr_rd(CSR_STATUS, rd);
    check_eq("status_after_reset", rd, 0);

    // 40 beats from 0x1000, sink always ready: bursts 16,16,8
    ready_mode = 1;
    wait_rand = 1'b0;
    start_job(30'h1000, 40, 1'b0);
    wait_done("basic", 500);
    check_eq("basic_bursts", job_accepts, 3);
    check_eq("basic_irq_off", irq, 1'b0);

    // first request held off by three waitrequest cycles
    ready_mode = 2;
    forced_wait = 3;
    start_job(30'h4000, 20, 1'b0);
    wait_done("wait", 500);
    check_eq("wait_req_cycles", first_req_cycles, 4);
    check_eq("wait_hold_err", hold_err, 0);
    check_eq("wait_bursts", job_accepts, 2);

    // sink stalled: credit must cap requested beats at the FIFO depth
    ready_mode = 0;
    wait_rand = 1'b1;
    start_job(30'h8000, 200, 1'b0);
    repeat (300) @(posedge clk_clk);
    #1;
    check_eq("stall_accepted", accepted_beats, FIFO_DEPTH);
    check_eq("stall_streamed", streamed_beats, 0);
    check_eq("stall_m0_read", m0_read, 1'b0);
    check_eq("stall_st_valid", st_valid, 1'b1);
    check_eq("stall_state", dbg_state, ST_ISSUE);
    ready_mode = 2;
    wait_done("stall", 3000);
    check_eq("stall_credit", (max_inflight <= FIFO_DEPTH), 1'b1);

    // zero-length job with interrupt enabled
    acc_before = accept_cnt;
    csr_wr(CSR_LEN, 0);
    csr_wr(CSR_CTRL, 32'h3);
    check_eq("zero_irq_early", irq, 1'b0);
    @(posedge clk_clk); #1;
    check_eq("zero_irq", irq, 1'b1);
    csr_rd(CSR_STATUS, rd);
    check_eq("zero_status", rd, 32'h2);
    csr_wr(CSR_STATUS, 32'h2);
    @(posedge clk_clk); #1;
    check_eq("zero_irq_clear", irq, 1'b0);
    repeat (5) @(posedge clk_clk);
    #1;
    check_eq("zero_no_read", accept_cnt, acc_before);
    check_eq("zero_state", dbg_state, ST_IDLE);
    csr_wr(CSR_CTRL, 32'h0);

    // GO and register writes while busy are ignored
    start_job(30'h3000, 40, 1'b0);
    csr_wr(CSR_LEN, 8);
    csr_wr(CSR_START, 32'h5000);
    csr_wr(CSR_CTRL, 32'h1);
    wait_done("busy_go", 2000);
    csr_rd(CSR_LEN, rd);
    check_eq("busy_go_len", rd, 40);
    csr_rd(CSR_START, rd);
    check_eq("busy_go_start", rd, 32'h3000);

    // reset in the middle of a job
    start_job(30'h6000, 40, 1'b0);
    n = 0;
    while (beats_seen < 10 && n < 2000) begin
      @(posedge clk_clk); #1;
      n++;
    end
    check_eq("mid_reached_10", (beats_seen >= 10), 1'b1);
    reset_reset_n = 1'b0;
    @(posedge clk_clk); #1;
    check_reset_outputs("mid_rst");
    reset_reset_n = 1'b1;
    exp_q.delete();
    exp_addr_q.delete();
    exp_burst_q.delete();
    job_len = 0;
    beats_seen = 0;
    req_cycles = 0;
    n = 0;
    while (pend_addr_q.size() > 0 && n < 500) begin
      @(posedge clk_clk); #1;
      n++;
    end
    repeat (3) @(posedge clk_clk);
    #1;
    check_eq("mid_dropped", st_valid, 1'b0);
    csr_rd(CSR_LEN, rd);
    check_eq("mid_len_cleared", rd, 0);
    start_job(30'h2000, 4, 1'b0);
    wait_done("after_rst", 500);
    check_eq("after_rst_bursts", job_accepts, 1);
    check_eq("final_hold_err", hold_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
